// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory block.
//   MAZE_WIDTH  default row/col index width (maze is 2^w x 2^w cells)
//   LOAD_BYTES  number of wall bytes in one full load at the default width
//   PATH_CNT_W  width of path_count at the default width
//   maze_state_e  controller states
package maze_pkg;

  localparam int MAZE_WIDTH = 6;
  localparam int LOAD_BYTES = (1 << (2 * MAZE_WIDTH)) / 8;
  localparam int PATH_CNT_W = 2 * MAZE_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SERVE    = 2'd2,
    FINISHED = 2'd3
  } maze_state_e;

endpackage

// File: rtl/maze_bitram.sv
// Single-bit-per-cell storage for a square maze, organised as bytes.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   byte_we/addr/data   8-bit write port used while loading
//   bit_re              capture bit_addr's stored bit into bit_q
//   bit_set             set the bit at bit_addr to 1
//   bit_addr            cell address {row, col}
//   bit_q               registered read result, holds when bit_re is low
//   bit_cur             current stored bit at bit_addr (combinational)
// Array contents are not reset.
module maze_bitram #(
  parameter int addr_w = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_we,
  input  logic [addr_w-4:0] byte_addr,
  input  logic [7:0]        byte_data,
  input  logic              bit_re,
  input  logic              bit_set,
  input  logic [addr_w-1:0] bit_addr,
  output logic              bit_q,
  output logic              bit_cur
);

  logic [7:0] mem [0:(1 << (addr_w - 3)) - 1];

  // A load write and a bit set never coincide in the controller; byte write
  // wins if they ever do.
  always_ff @(posedge clk) begin
    if (byte_we) begin
      mem[byte_addr] <= byte_data;
    end else if (bit_set) begin
      mem[bit_addr[addr_w-1:3]][bit_addr[2:0]] <= 1'b1;
    end
  end

  assign bit_cur = mem[bit_addr[addr_w-1:3]][bit_addr[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else if (bit_re) begin
      bit_q <= bit_cur;
    end
  end

endmodule

// File: rtl/maze_mem.sv
// Maze wall/path memory with load sequencer for a maze solver.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_start                 pulse: begin a load (from IDLE or FINISHED)
//   load_valid, load_data      row-major wall bytes, bit k = column 8j+k
//   load_ready                 high only while loading
//   solver_rst_n               releases the solver once a load completes
//   row, col, maze_oe          read request; maze_in valid the next cycle
//   maze_we                    mark (row, col) as on the path
//   maze_in                    registered wall bit of last read cell
//   done                       solver found the exit
//   path_count                 distinct cells marked (saturating)
//   we_on_wall                 sticky: a mark targeted a wall
// Optional: define MAZE_MEM_PATH_EN to build the path bitmap, path_count and
// we_on_wall; otherwise maze_we is ignored and both outputs read 0.
//
// state    | meaning
// IDLE     | after reset, waiting for load_start
// LOAD     | accepting wall bytes, clearing path bits
// SERVE    | solver running: reads and path marks
// FINISHED | solver done; memory frozen until the next load_start
module maze_mem
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [7:0]              load_data,
  output logic                    load_ready,
  output logic                    solver_rst_n,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    done,
  output logic [2*maze_width:0]   path_count,
  output logic                    we_on_wall
);

  localparam int CELL_W = 2 * maze_width;
  localparam int BYTE_W = CELL_W - 3;

  maze_state_e       state, state_nxt;
  logic [BYTE_W-1:0] byte_cnt;
  logic              accept;
  logic              last_byte;
  logic              serve;
  logic              enter_load;
  logic [CELL_W-1:0] cell_addr;
  logic              wall_cur;

  assign cell_addr  = {row, col};
  assign accept     = load_valid && load_ready;
  assign last_byte  = accept && (&byte_cnt);
  assign enter_load = (state != LOAD) && (state_nxt == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load_start) state_nxt = LOAD;
      LOAD:     if (last_byte)  state_nxt = SERVE;
      SERVE:    if (done)       state_nxt = FINISHED;
      FINISHED: if (load_start) state_nxt = LOAD;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready   = 1'b0;
    solver_rst_n = 1'b0;
    serve        = 1'b0;
    case (state)
      LOAD:  load_ready = 1'b1;
      SERVE: begin
        solver_rst_n = 1'b1;
        serve        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (enter_load) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  maze_bitram #(.addr_w(CELL_W)) u_wall (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_we   (accept),
    .byte_addr (byte_cnt),
    .byte_data (load_data),
    .bit_re    (serve && maze_oe),
    .bit_set   (1'b0),
    .bit_addr  (cell_addr),
    .bit_q     (maze_in),
    .bit_cur   (wall_cur)
  );

`ifdef MAZE_MEM_PATH_EN
  logic path_cur;
  logic path_q_unused;
  logic mark_ok;
  logic new_mark;

  assign mark_ok  = serve && maze_we && !wall_cur;
  assign new_mark = mark_ok && !path_cur;

  // Each accepted load byte clears the matching eight path bits.
  maze_bitram #(.addr_w(CELL_W)) u_path (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_we   (accept),
    .byte_addr (byte_cnt),
    .byte_data (8'h00),
    .bit_re    (1'b0),
    .bit_set   (mark_ok),
    .bit_addr  (cell_addr),
    .bit_q     (path_q_unused),
    .bit_cur   (path_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      path_count <= '0;
      we_on_wall <= 1'b0;
    end else if (enter_load) begin
      path_count <= '0;
      we_on_wall <= 1'b0;
    end else begin
      if (new_mark && !(&path_count)) begin
        path_count <= path_count + 1'b1;
      end
      if (serve && maze_we && wall_cur) begin
        we_on_wall <= 1'b1;
      end
    end
  end
`else
  logic unused_we;
  assign unused_we  = maze_we;
  assign path_count = '0;
  assign we_on_wall = 1'b0;
`endif

endmodule

// File: tb/tb_maze_mem.sv
module tb_maze_mem;

  localparam int W = 6;
`ifdef MAZE_MEM_PATH_EN
  localparam bit PATH_EN = 1'b1;
`else
  localparam bit PATH_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_start = 1'b0;
  logic         load_valid = 1'b0;
  logic [7:0]   load_data = 8'h00;
  logic         load_ready;
  logic         solver_rst_n;
  logic [W-1:0] row = '0;
  logic [W-1:0] col = '0;
  logic         maze_oe = 1'b0;
  logic         maze_we = 1'b0;
  logic         maze_in;
  logic         done = 1'b0;
  logic [2*W:0] path_count;
  logic         we_on_wall;

  int vectors = 0;
  int miscompares = 0;

  maze_mem #(.maze_width(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .solver_rst_n (solver_rst_n),
    .row          (row),
    .col          (col),
    .maze_oe      (maze_oe),
    .maze_we      (maze_we),
    .maze_in      (maze_in),
    .done         (done),
    .path_count   (path_count),
    .we_on_wall   (we_on_wall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: all walls except cell (0,0)
  // mode 1: byte 8 = A5 (row 1 cols 0..7), row 5 fully open, rest walls
  function automatic logic [7:0] pat(input int mode, input int idx);
    if (mode == 0) return (idx == 0) ? 8'hFE : 8'hFF;
    if (idx == 8) return 8'hA5;
    if (idx >= 40 && idx < 48) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic load_bytes(input int mode, input int first, input int n, input bit toggle);
    for (int i = first; i < first + n; i++) begin
      load_data  = pat(mode, i);
      load_valid = 1'b1;
      tick();
      if (toggle) begin
        load_valid = 1'b0;
        load_data  = 8'h00;
        tick();
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic rd(input int r, input int c);
    row = W'(r);
    col = W'(c);
    maze_oe = 1'b1;
    tick();
    maze_oe = 1'b0;
  endtask

  task automatic wr(input int r, input int c);
    row = W'(r);
    col = W'(c);
    maze_we = 1'b1;
    tick();
    maze_we = 1'b0;
  endtask

  logic [7:0] row1_exp;

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_solver_rst_n", solver_rst_n, 0);
    chk("rst_maze_in", maze_in, 0);
    chk("rst_path_count", path_count, 0);
    chk("rst_we_on_wall", we_on_wall, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_load_ready", load_ready, 0);

    // full continuous load, mode 0
    pulse_start();
    chk("load_ready_in_load", load_ready, 1);
    load_bytes(0, 0, 511, 1'b0);
    chk("solver_low_at_511", solver_rst_n, 0);
    chk("ready_high_at_511", load_ready, 1);
    load_bytes(0, 511, 1, 1'b0);
    chk("ready_low_after_512", load_ready, 0);
    chk("solver_high_after_512", solver_rst_n, 1);

    rd(0, 0);
    chk("rd_0_0", maze_in, 0);
    rd(0, 1);
    chk("rd_0_1", maze_in, 1);
    row = W'(0); col = W'(0);
    tick();
    chk("maze_in_hold", maze_in, 1);

    // load_start in SERVE is ignored
    pulse_start();
    chk("serve_ignores_start_ready", load_ready, 0);
    chk("serve_ignores_start_solver", solver_rst_n, 1);

    // done -> FINISHED, then reload with load_valid toggling
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("finished_solver_low", solver_rst_n, 0);
    pulse_start();
    chk("reload_ready", load_ready, 1);
    load_bytes(1, 0, 511, 1'b1);
    chk("toggle_solver_low_511", solver_rst_n, 0);
    chk("toggle_ready_511", load_ready, 1);
    load_bytes(1, 511, 1, 1'b1);
    chk("toggle_solver_high_512", solver_rst_n, 1);

    row1_exp = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      rd(1, k);
      chk($sformatf("row1_col%0d", k), maze_in, row1_exp[k]);
    end
    rd(1, 8);
    chk("row1_col8", maze_in, 1);

    // path marking
    wr(5, 5);
    wr(5, 5);
    wr(5, 6);
    chk("path_count_2", path_count, PATH_EN ? 2 : 0);
    chk("no_wall_err", we_on_wall, 0);

    row = W'(5); col = W'(7);
    maze_oe = 1'b1;
    maze_we = 1'b1;
    tick();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    chk("oe_we_same_cycle_rd", maze_in, 0);
    chk("oe_we_same_cycle_cnt", path_count, PATH_EN ? 3 : 0);

    wr(4, 0);
    chk("we_on_wall_set", we_on_wall, PATH_EN ? 1 : 0);
    chk("wall_write_cnt", path_count, PATH_EN ? 3 : 0);
    rd(4, 0);
    chk("wall_unchanged", maze_in, 1);
    wr(5, 9);
    chk("we_on_wall_sticky", we_on_wall, PATH_EN ? 1 : 0);
    chk("path_count_4", path_count, PATH_EN ? 4 : 0);

    // FINISHED freezes everything
    done = 1'b1;
    tick();
    done = 1'b0;
    wr(5, 8);
    chk("finished_cnt_frozen", path_count, PATH_EN ? 4 : 0);
    rd(5, 10);
    chk("finished_maze_in_frozen", maze_in, 1);
    pulse_start();
    chk("finished_to_load", load_ready, 1);
    chk("load_clears_cnt", path_count, 0);
    chk("load_clears_err", we_on_wall, 0);

    // reset mid-load aborts; restart from byte 0
    load_bytes(1, 0, 100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midload_rst_ready", load_ready, 0);
    chk("midload_rst_solver", solver_rst_n, 0);
    chk("midload_rst_maze_in", maze_in, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    load_bytes(0, 0, 511, 1'b0);
    chk("restart_solver_low_511", solver_rst_n, 0);
    load_bytes(0, 511, 1, 1'b0);
    chk("restart_solver_high_512", solver_rst_n, 1);
    rd(0, 0);
    chk("restart_rd_0_0", maze_in, 0);
    rd(1, 0);
    chk("restart_rd_1_0", maze_in, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
